// File: rtl/aes128_encrypt_iter.sv
// aes128_encrypt_iter: iterative AES-128 encryption core. The core computes one
// full cipher round per clock and expands the key on the fly, over NR = 10 rounds.
// Blocks enter through a valid/ready input handshake and leave through a
// valid/ready output handshake.
// Optional feature macro: AES_FINAL_KEY_OUT_EN adds output final_key, the
// round-10 key that the decryption chain starts from.
module aes128_encrypt_iter #(
  parameter int unsigned NR = 10  // fixed for AES-128; other values unsupported
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] text_in,
  input  logic [0:127] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] text_out,
  output logic         busy
`ifdef AES_FINAL_KEY_OUT_EN
  ,
  output logic [0:127] final_key
`endif
);

  // Byte k of the block is element k; bytes 4c..4c+3 form column c.
  typedef logic [0:15][7:0] blk_t;

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  localparam logic [3:0] NrLast = 4'(NR);

  // Forward S-box; element x holds SubBytes(x).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic blk_t sub_bytes(blk_t s);
    blk_t o;
    for (int i = 0; i < 16; i++) o[i] = SBOX[s[i]];
    return o;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic blk_t shift_rows(blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4*c + r] = s[4*((c + r) % 4) + r];
      end
    end
    return o;
  endfunction

  // Each output byte is 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3] within its column.
  function automatic blk_t mix_columns(blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a0 = s[4*c + r];
        a1 = s[4*c + (r + 1) % 4];
        a2 = s[4*c + (r + 2) % 4];
        a3 = s[4*c + (r + 3) % 4];
        o[4*c + r] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      end
    end
    return o;
  endfunction

  // One step of the AES-128 key schedule: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon,
  // then each following word chains on the previous new word.
  function automatic blk_t key_expand(blk_t k, logic [7:0] rc);
    blk_t o;
    logic [0:3][7:0] t;
    t[0] = SBOX[k[13]] ^ rc;
    t[1] = SBOX[k[14]];
    t[2] = SBOX[k[15]];
    t[3] = SBOX[k[12]];
    for (int i = 0; i < 4; i++) o[i] = k[i] ^ t[i];
    for (int i = 4; i < 16; i++) o[i] = k[i] ^ o[i-4];
    return o;
  endfunction

  function automatic logic [7:0] rcon(logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  fsm_e       fsm_q, fsm_d;
  blk_t       state_q, state_d;
  blk_t       key_q, key_d;
  logic [3:0] rnd_q, rnd_d;

  blk_t rk, sr, mc, rnd_out;
  logic accept;

  assign accept = in_valid & in_ready;

  // Round datapath: the next round key plus the round result, with MixColumns
  // skipped on the final round.
  always_comb begin
    rk      = key_expand(key_q, rcon(rnd_q));
    sr      = shift_rows(sub_bytes(state_q));
    mc      = mix_columns(sr);
    rnd_out = (rnd_q == NrLast) ? (sr ^ rk) : (mc ^ rk);
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsm_q <= StIdle;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle:  if (accept) fsm_d = StRound;
      StRound: if (rnd_q == NrLast) fsm_d = StDone;
      StDone:  if (out_ready) fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  // FSM outputs, decoded from the current state only.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (fsm_q)
      StIdle:  in_ready  = 1'b1;
      StRound: busy      = 1'b1;
      StDone:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath next-state: load on accept, one round per ROUND cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    unique case (fsm_q)
      StIdle: begin
        if (accept) begin
          state_d = text_in ^ key_in;
          key_d   = key_in;
          rnd_d   = 4'd1;
        end
      end
      StRound: begin
        state_d = rnd_out;
        key_d   = rk;
        // Saturate at the last round so rnd never exceeds NR.
        if (rnd_q != NrLast) rnd_d = rnd_q + 4'd1;
      end
      StDone: begin
        if (out_ready) rnd_d = '0;
      end
      default: rnd_d = '0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  // state_q is only rewritten on accept or in ROUND, so it stays stable in DONE.
  assign text_out = state_q;

`ifdef AES_FINAL_KEY_OUT_EN
  // After the last round key_q holds the round-10 key and stays put until the next accept.
  assign final_key = key_q;
`endif

endmodule

// File: doc/aes128_encrypt_iter.md
Name: aes128_encrypt_iter

Overview:
Iterative AES-128 encryption core: the forward direction of the existing inverse-round decryption datapath. It runs one full cipher round per clock, with on-the-fly key expansion, over 10 rounds. Plaintext and key enter through a valid/ready input handshake, and ciphertext leaves through a valid/ready output handshake. It feeds ciphertext test vectors and round-10 keys to the decryption chain.

Parameters:
NR, 10, number of cipher rounds; fixed for AES-128, other values unsupported.

Ports:
Clk  input  1  single clock, all state on rising edge
Reset_n  input  1  asynchronous active-low reset
in_valid  input  1  plaintext/key offered
in_ready  output  1  core can accept a block
text_in  input  [0:127]  plaintext; byte k = bits [8k:8k+7], column-major state (bytes 0-3 = column 0)
key_in  input  [0:127]  cipher key, same byte order
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts ciphertext
text_out  output  [0:127]  ciphertext, same byte order
busy  output  1  high in ROUND state

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, text_out=0, internal state/key registers=0, round counter=0.
- FSM states are IDLE, ROUND and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg <= text_in ^ key_in; key_reg <= key_in; rnd <= 1; go to ROUND.
- ROUND:
  - in_ready=0, busy=1.
  - Each cycle: rk = KeyExpand(key_reg, Rcon[rnd]); key_reg <= rk.
  - When rnd<NR: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk.
  - When rnd==NR: state_reg <= ShiftRows(SubBytes(state_reg)) ^ rk, with no MixColumns; go to DONE.
  - rnd increments each cycle.
- Rcon sequence for rnd 1..10: 01,02,04,08,10,20,40,80,1b,36.
- KeyExpand:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,00,00,00}.
  - wi' = wi ^ w(i-1)' for i = 1..3.
  - Words are 32-bit columns in byte order.
- DONE:
  - out_valid=1; text_out = state_reg, held stable while out_valid=1 && out_ready=0.
  - On out_ready: go to IDLE next cycle; out_valid drops.
- Latency: accept at edge 0; out_valid is high in the cycle after edge 10 (10 ROUND cycles).
  - With out_ready tied high, the sustained throughput is one block per 12 cycles.
- in_valid while not in IDLE is ignored; text_in/key_in are sampled only on the accept edge.
- Input changes after the accept edge have no effect on the block in flight.
- out_ready while out_valid=0 is ignored.
- DONE with out_ready=1 and in_valid=1 in the same cycle: no accept (in_ready=0); the block is accepted one cycle later in IDLE.
- rnd never exceeds NR; it is cleared on entry to IDLE.
- Reset_n assertion mid-ROUND or in DONE: immediate return to reset values, and the block in flight is discarded. The first accept is possible on the first edge after deassertion.
- S-box: combinational 256-entry forward table; 16 instances for the state plus 4 for key expansion.

Optional Feature:
Macro AES_FINAL_KEY_OUT_EN.
- Defined:
  - Adds output final_key [0:127], the round-10 key (key_reg after the last round).
  - final_key is valid and stable whenever out_valid=1, so the decryption chain can start with it.
  - Reset value is 0.
- Undefined: the port is absent, and no extra logic is generated beyond existing key_reg.

Test Plan:
- FIPS-197 App.B: text_in=3243f6a8885a308d313198a2e0370734, key_in=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_valid on cycle 11 after accept, text_out=3925841d02dc09fbdc118597196a0b32; with AES_FINAL_KEY_OUT_EN, final_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 App.C.1: text_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f -> text_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> text_out constant, in_ready=0 throughout, and in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- Input change mid-run: change text_in/key_in every cycle during ROUND -> result still equals the App.B ciphertext.
- Reset mid-op: drop Reset_n at ROUND cycle 5 -> out_valid=0, in_ready=1 immediately; the following App.C.1 run produces the correct ciphertext.
- Back-to-back: in_valid=1 held with two blocks queued and out_ready=1 -> accepts exactly 12 cycles apart, both ciphertexts correct.
